// File: rtl/axi4_heater_regs.sv
// AXI4-Lite register slave (CTRL/DUTY/PERIOD/MASK) with PWM heater-enable engine.
// Define AXI4_HEATER_WSTRB_EN to honour WSTRB byte lanes; otherwise writes are full-word.
module axi4_heater_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_HEATERS        = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_HEATERS-1:0]            heat_en
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t r_wstate, w_wnext;
    rstate_t r_rstate, w_rnext;

    logic [31:0]            r_regs [4];
    logic [31:0]            r_rdata;
    logic [31:0]            w_wmerge;
    logic [1:0]             w_waddr;
    logic [1:0]             w_raddr;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic [15:0]            r_cnt;
    logic [15:0]            r_p;
    logic [15:0]            r_d;
    logic [NUM_HEATERS-1:0] r_heat;
    logic                   w_enable;
    logic                   w_hold;
    logic                   w_unused;

    assign w_waddr = S_AXI_AWADDR[3:2];
    assign w_raddr = S_AXI_ARADDR[3:2];

    // ---------------- write channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_wstate <= W_IDLE;
        else          r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext       = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_wnext = W_ADDR;
            W_ADDR: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                w_wr_en       = S_AXI_AWVALID && S_AXI_WVALID;
                w_wnext       = w_wr_en ? W_RESP : W_IDLE;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_wmerge = S_AXI_WDATA;
`ifdef AXI4_HEATER_WSTRB_EN
        w_wmerge = r_regs[w_waddr];
        for (int unsigned b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) w_wmerge[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[w_waddr] <= w_wmerge;
        end
    end

    assign S_AXI_BRESP = 2'b00;

    // ---------------- read channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_rstate <= R_IDLE;
        else          r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext       = r_rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        w_rd_en       = 1'b0;
        case (r_rstate)
            R_IDLE: if (S_AXI_ARVALID) w_rnext = R_ADDR;
            R_ADDR: begin
                S_AXI_ARREADY = 1'b1;
                w_rd_en       = S_AXI_ARVALID;
                w_rnext       = w_rd_en ? R_DATA : R_IDLE;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Captured before the same-edge write commit lands, so a colliding read sees the old value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     r_rdata <= '0;
        else if (w_rd_en) r_rdata <= r_regs[w_raddr];
    end

    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RRESP = 2'b00;

    // ---------------- PWM engine ----------------
    assign w_enable = r_regs[0][0];
    assign w_hold   = !w_enable || (r_p == '0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_d    <= '0;
            r_heat <= '0;
        end else begin
            if (w_hold || (r_cnt == r_p - 16'd1)) begin
                r_cnt <= '0;
                r_p   <= r_regs[2][15:0];
                r_d   <= r_regs[1][15:0];
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_heat <= (w_enable && (r_p != '0) && (r_cnt < r_d)) ? r_regs[3][NUM_HEATERS-1:0] : '0;
        end
    end

    assign heat_en = r_heat;

`ifdef AXI4_HEATER_WSTRB_EN
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};
`endif

endmodule

// File: tb/tb_axi4_heater_regs.sv
// Directed self-checking bench for axi4_heater_regs: reset, register access, PWM, handshakes, strobes.
module tb_axi4_heater_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARADDR = '0;
    logic [2:0]  ARPROT = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [7:0]  heat_en;

    int errors = 0;
    int checks = 0;

    logic       rec = 1'b0;
    logic [7:0] samp [$];

    always #5 ACLK = ~ACLK;

    axi4_heater_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .NUM_HEATERS(8)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .heat_en(heat_en)
    );

    always begin
        @(posedge ACLK);
        #1;
        if (rec) samp.push_back(heat_en);
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int lat, output int bwait, output bit ok);
        ok = 1'b1;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        lat = 1;
        step();
        while (!(AWREADY && WREADY) && lat < 20) begin step(); lat++; end
        if (!(AWREADY && WREADY)) ok = 1'b0;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        bwait = 0;
        while (!BVALID && bwait < 20) begin step(); bwait++; end
        if (!BVALID) ok = 1'b0;
        resp = BRESP;
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output int rwait, output bit ok);
        ok = 1'b1;
        ARADDR = addr; ARVALID = 1'b1;
        lat = 1;
        step();
        while (!ARREADY && lat < 20) begin step(); lat++; end
        if (!ARREADY) ok = 1'b0;
        step();
        ARVALID = 1'b0;
        rwait = 0;
        while (!RVALID && rwait < 20) begin step(); rwait++; end
        if (!RVALID) ok = 1'b0;
        data = RDATA; resp = RRESP;
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat, w; bit ok;
        ARESETN = 1'b0;
        #200;
        checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_hs: got %b required 00000", {AWREADY, WREADY, BVALID, ARREADY, RVALID});
        end
        checks++;
        if ({BRESP, RRESP, RDATA, heat_en} !== 44'h0) begin
            errors++; $display("FAIL reset_data: rdata=%h heat=%h bresp=%b rresp=%b required 0", RDATA, heat_en, BRESP, RRESP);
        end
        ARESETN = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r, lat, w, ok);
            checks++;
            if (!ok || d !== 32'h0 || r !== 2'b00) begin
                errors++; $display("FAIL reset_read[%0d]: ok=%0d data=%h resp=%b required 00000000/00", i, ok, d, r);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] d; logic [1:0] r; int lat, w; bit ok;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, r, lat, w, ok);
            checks++;
            if (!ok || r !== 2'b00 || lat != 1 || w != 0) begin
                errors++; $display("FAIL write[%0d]: ok=%0d bresp=%b ready_lat=%0d bvalid_wait=%0d required 1/00/1/0", i, ok, r, lat, w);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r, lat, w, ok);
            checks++;
            if (!ok || d !== 32'(i + 1) || r !== 2'b00 || lat != 1 || w != 0) begin
                errors++; $display("FAIL readback[%0d]: ok=%0d data=%h lat=%0d wait=%0d required %h/1/0", i, ok, d, lat, w, 32'(i + 1));
            end
        end
    endtask

    task automatic test_pwm();
        logic [1:0] r; int lat, w; bit ok;
        int ones, bad, adj, n1, n3, order_err, align_err, first_start;
        bit seen3;
        int rs [$];
        int rl [$];
        axi_write(4'hC, 32'hFF, 4'hF, r, lat, w, ok);
        axi_write(4'h4, 32'd1, 4'hF, r, lat, w, ok);
        axi_write(4'h8, 32'd4, 4'hF, r, lat, w, ok);
        axi_write(4'h0, 32'd1, 4'hF, r, lat, w, ok);
        repeat (8) step();
        samp.delete();
        rec = 1'b1;
        repeat (16) step();
        rec = 1'b0;
        ones = 0; bad = 0; adj = 0;
        for (int i = 0; i < samp.size(); i++) begin
            if (samp[i] == 8'hFF) ones++;
            else if (samp[i] != 8'h00) bad++;
            if (i > 0 && samp[i] == 8'hFF && samp[i-1] == 8'hFF) adj++;
        end
        checks++;
        if (ones != 4 || bad != 0 || adj != 0) begin
            errors++; $display("FAIL pwm_duty1: ones=%0d bad=%0d adjacent=%0d required 4/0/0 in 16 cycles", ones, bad, adj);
        end
        samp.delete();
        rec = 1'b1;
        repeat (8) step();
        axi_write(4'h4, 32'd3, 4'hF, r, lat, w, ok);
        repeat (24) step();
        rec = 1'b0;
        bad = 0;
        for (int i = 0; i < samp.size(); i++) begin
            if (samp[i] != 8'hFF && samp[i] != 8'h00) bad++;
            if (samp[i] == 8'hFF && (i == 0 || samp[i-1] != 8'hFF)) begin
                int j;
                j = i;
                while (j < samp.size() && samp[j] == 8'hFF) j++;
                if (j < samp.size()) begin rs.push_back(i); rl.push_back(j - i); end
            end
        end
        n1 = 0; n3 = 0; order_err = 0; align_err = 0; seen3 = 1'b0;
        first_start = (rs.size() > 0) ? rs[0] : 0;
        for (int k = 0; k < rs.size(); k++) begin
            if (rl[k] == 1) begin n1++; if (seen3) order_err++; end
            else if (rl[k] == 3) begin n3++; seen3 = 1'b1; end
            else order_err++;
            if (((rs[k] - first_start) % 4) != 0) align_err++;
        end
        checks++;
        if (bad != 0 || order_err != 0 || align_err != 0 || n1 < 2 || n3 < 2) begin
            errors++; $display("FAIL pwm_duty_change: bad=%0d order_err=%0d align_err=%0d runs1=%0d runs3=%0d required 0/0/0/>=2/>=2",
                               bad, order_err, align_err, n1, n3);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] d; logic [1:0] r; int lat, w, bad; bit ok;
        AWADDR = 4'h4; WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1; AWVALID = 1'b0;
        bad = 0;
        repeat (3) begin step(); if (AWREADY || WREADY) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL w_only_accepted: early_ready_cycles=%0d required 0", bad); end
        AWVALID = 1'b1;
        step();
        checks++;
        if (!(AWREADY && WREADY)) begin errors++; $display("FAIL aw_w_ready: got %b%b required 11", AWREADY, WREADY); end
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        WDATA = 32'h66; AWVALID = 1'b1; WVALID = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!BVALID || AWREADY || WREADY) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bvalid_hold: bad_cycles=%0d required 0", bad); end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0) begin errors++; $display("FAIL bvalid_release: got %b required 0", BVALID); end
        axi_read(4'h4, d, r, lat, w, ok);
        checks++;
        if (!ok || d !== 32'h55) begin errors++; $display("FAIL no_second_write: data=%h required 00000055", d); end

        ARADDR = 4'h4; ARVALID = 1'b1;
        step();
        checks++;
        if (ARREADY !== 1'b1) begin errors++; $display("FAIL arready: got %b required 1", ARREADY); end
        step();
        ARVALID = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!RVALID || RDATA !== 32'h55) bad++;
            step();
        end
        axi_write(4'h4, 32'h77, 4'hF, r, lat, w, ok);
        checks++;
        if (bad != 0 || !RVALID || RDATA !== 32'h55) begin
            errors++; $display("FAIL rdata_hold: bad_cycles=%0d rvalid=%b rdata=%h required 0/1/00000055", bad, RVALID, RDATA);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        axi_read(4'h4, d, r, lat, w, ok);
        checks++;
        if (!ok || d !== 32'h77) begin errors++; $display("FAIL write_during_rhold: data=%h required 00000077", d); end

        AWADDR = 4'hC; WDATA = 32'h0F; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'hC; ARVALID = 1'b1;
        step();
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        checks++;
        if (!RVALID || !BVALID || RDATA !== 32'hFF) begin
            errors++; $display("FAIL collide_old_value: rvalid=%b bvalid=%b rdata=%h required 1/1/000000ff", RVALID, BVALID, RDATA);
        end
        BREADY = 1'b1; RREADY = 1'b1;
        step();
        BREADY = 1'b0; RREADY = 1'b0;
        axi_read(4'hC, d, r, lat, w, ok);
        checks++;
        if (!ok || d !== 32'h0F) begin errors++; $display("FAIL collide_new_value: data=%h required 0000000f", d); end
    endtask

    task automatic test_back_to_back();
        int nrdy, nb;
        AWADDR = 4'h8; WDATA = 32'd4; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        nrdy = 0; nb = 0;
        repeat (12) begin step(); if (AWREADY) nrdy++; if (BVALID) nb++; end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        checks++;
        if (nrdy != 4 || nb != 4) begin errors++; $display("FAIL b2b_write: accepts=%0d bvalids=%0d required 4/4", nrdy, nb); end
        step();
        ARADDR = 4'h8; ARVALID = 1'b1; RREADY = 1'b1;
        nrdy = 0; nb = 0;
        repeat (12) begin step(); if (ARREADY) nrdy++; if (RVALID && RDATA === 32'd4) nb++; end
        ARVALID = 1'b0; RREADY = 1'b0;
        checks++;
        if (nrdy != 4 || nb != 4) begin errors++; $display("FAIL b2b_read: accepts=%0d rvalids=%0d required 4/4", nrdy, nb); end
        step();
    endtask

    task automatic test_strobe();
        logic [31:0] d, exp; logic [1:0] r; int lat, w; bit ok;
`ifdef AXI4_HEATER_WSTRB_EN
        exp = 32'h11BB33DD;
`else
        exp = 32'hAABBCCDD;
`endif
        axi_write(4'hC, 32'h11223344, 4'hF, r, lat, w, ok);
        axi_write(4'hC, 32'hAABBCCDD, 4'b0101, r, lat, w, ok);
        axi_read(4'hC, d, r, lat, w, ok);
        checks++;
        if (!ok || d !== exp) begin errors++; $display("FAIL strobe: data=%h required %h", d, exp); end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] d; logic [1:0] r; int lat, w, bad; bit ok;
        axi_write(4'hC, 32'hA5, 4'hF, r, lat, w, ok);
        axi_write(4'h8, 32'd4, 4'hF, r, lat, w, ok);
        axi_write(4'h4, 32'd8, 4'hF, r, lat, w, ok);
        axi_write(4'h0, 32'd1, 4'hF, r, lat, w, ok);
        repeat (4) step();
        checks++;
        if (heat_en !== 8'hA5) begin errors++; $display("FAIL full_duty: heat_en=%h required a5", heat_en); end
        AWADDR = 4'h8; WDATA = 32'h1234; AWVALID = 1'b1; WVALID = 1'b1;
        step();
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b1) begin errors++; $display("FAIL pending_bvalid: got %b required 1", BVALID); end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if (heat_en !== 8'h00 || BVALID !== 1'b0) begin
            errors++; $display("FAIL async_reset: heat_en=%h bvalid=%b required 00/0", heat_en, BVALID);
        end
        #20;
        @(negedge ACLK);
        ARESETN = 1'b1;
        BREADY = 1'b1;
        bad = 0;
        repeat (3) begin step(); if (BVALID || heat_en != 8'h00) bad++; end
        BREADY = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL post_reset_quiet: bad_cycles=%0d required 0", bad); end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r, lat, w, ok);
            checks++;
            if (!ok || d !== 32'h0) begin errors++; $display("FAIL post_reset_read[%0d]: data=%h required 00000000", i, d); end
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_pwm();
        test_handshake();
        test_back_to_back();
        test_strobe();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
